iomem_wb_bridge: RTL and testbench

- Parametrised PicoSoC iomem-to-Wishbone master bridge with NUM_SLAVES address-decoded slave ports.
- Sits between the picosoc iomem bus and the Wishbone peripherals at and above 0x0300_0000 (LED/button block, user project wrapper).
- Selects exactly one slave per transfer and muxes ack/data by decode, never by OR. Passes true byte selects.
- Bus timeout and unmapped-slave error response, so a missing or hung slave cannot stall the CPU.

---
 rtl/iomem_wb_bridge.sv | 181 ++++++++++++++++++
 tb/tb_iomem_wb_bridge.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/iomem_wb_bridge.sv
// PicoSoC iomem to Wishbone master bridge with one-hot address-decoded slave selects, bus timeout and unmapped-slave error response.
// Latency: 2 cycles valid-to-ready with a zero-wait slave. Backpressure: the iomem request is held until the one-cycle iomem_ready.
module iomem_wb_bridge #(
    parameter logic [31:0] WB_BASE    = 32'h0300_0000,
    parameter logic [31:0] WB_MASK    = 32'hFF00_0000,
    parameter int          NUM_SLAVES = 4,
    parameter int          SLV_LSB    = 16,
    parameter int          TO_W       = 8,
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     iomem_valid,
    output logic                     iomem_ready,
    input  logic [3:0]               iomem_wstrb,
    input  logic [31:0]              iomem_addr,
    input  logic [31:0]              iomem_wdata,
    output logic [31:0]              iomem_rdata,
    output logic                     wbm_cyc_o,
    output logic                     wbm_stb_o,
    output logic                     wbm_we_o,
    output logic [3:0]               wbm_sel_o,
    output logic [31:0]              wbm_adr_o,
    output logic [31:0]              wbm_dat_o,
    output logic [NUM_SLAVES-1:0]    wbm_slv_sel_o,
    input  logic [NUM_SLAVES-1:0]    wbm_ack_i,
    input  logic [32*NUM_SLAVES-1:0] wbm_dat_i,
    output logic                     timeout_o,
    output logic [7:0]               err_count_o
);
    localparam int               IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [IDX_W:0]   NS_L  = (IDX_W+1)'(NUM_SLAVES);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_RESP} state_t;

    state_t                  r_state, w_state_nxt;
    logic                    r_cyc, w_cyc_nxt;
    logic                    r_we, w_we_nxt;
    logic [3:0]              r_sel, w_sel_nxt;
    logic [31:0]             r_adr, w_adr_nxt;
    logic [31:0]             r_dat, w_dat_nxt;
    logic [NUM_SLAVES-1:0]   r_slv_sel, w_slv_sel_nxt;
    logic [TO_W-1:0]         r_cnt, w_cnt_nxt;
    logic                    r_ready, w_ready_nxt;
    logic [31:0]             r_rdata, w_rdata_nxt;
    logic                    r_timeout, w_timeout_nxt;
    logic [7:0]              r_err, w_err_nxt;

    logic                    w_hit;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_idx_ok;
    logic [NUM_SLAVES-1:0]   w_dec;
    logic                    w_ack;
    logic [31:0]             w_sdat;
    logic [7:0]              w_err_inc;

    assign w_hit     = (iomem_addr & WB_MASK) == WB_BASE;
    assign w_idx     = iomem_addr[SLV_LSB +: IDX_W];
    assign w_idx_ok  = {1'b0, w_idx} < NS_L;
    assign w_err_inc = (r_err == 8'hFF) ? r_err : r_err + 8'd1;

    // Ack and read data are steered by the latched one-hot select, so a stray ack from another slave never completes the transfer.
    always_comb begin
        w_dec  = '0;
        w_ack  = 1'b0;
        w_sdat = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_dec[i] = (w_idx == IDX_W'(i));
            if (r_slv_sel[i]) begin
                w_ack  = wbm_ack_i[i];
                w_sdat = wbm_dat_i[32*i +: 32];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cyc_nxt     = r_cyc;
        w_we_nxt      = r_we;
        w_sel_nxt     = r_sel;
        w_adr_nxt     = r_adr;
        w_dat_nxt     = r_dat;
        w_slv_sel_nxt = r_slv_sel;
        w_cnt_nxt     = r_cnt;
        w_ready_nxt   = 1'b0;
        w_rdata_nxt   = r_rdata;
        w_timeout_nxt = 1'b0;
        w_err_nxt     = r_err;
        case (r_state)
            ST_IDLE: begin
                if (iomem_valid && w_hit && !r_ready) begin
                    w_adr_nxt = iomem_addr;
                    w_dat_nxt = iomem_wdata;
                    w_sel_nxt = (|iomem_wstrb) ? iomem_wstrb : 4'hF;
                    w_cnt_nxt = '0;
                    if (w_idx_ok) begin
                        w_we_nxt      = |iomem_wstrb;
                        w_cyc_nxt     = 1'b1;
                        w_slv_sel_nxt = w_dec;
                        w_state_nxt   = ST_ACTIVE;
                    end else begin
                        w_rdata_nxt = ERR_DATA;
                        w_err_nxt   = w_err_inc;
                        w_ready_nxt = 1'b1;
                        w_state_nxt = ST_RESP;
                    end
                end
            end
            ST_ACTIVE: begin
                if (w_ack) begin
                    w_cyc_nxt     = 1'b0;
                    w_we_nxt      = 1'b0;
                    w_slv_sel_nxt = '0;
                    w_rdata_nxt   = r_we ? 32'h0 : w_sdat;
                    w_ready_nxt   = 1'b1;
                    w_state_nxt   = ST_RESP;
                end else if (r_cnt == TO_LAST) begin
                    w_cyc_nxt     = 1'b0;
                    w_we_nxt      = 1'b0;
                    w_slv_sel_nxt = '0;
                    w_rdata_nxt   = ERR_DATA;
                    w_timeout_nxt = 1'b1;
                    w_err_nxt     = w_err_inc;
                    w_ready_nxt   = 1'b1;
                    w_state_nxt   = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + TO_W'(1);
                end
            end
            ST_RESP: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_sel     <= '0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_slv_sel <= '0;
            r_cnt     <= '0;
            r_ready   <= 1'b0;
            r_rdata   <= '0;
            r_timeout <= 1'b0;
            r_err     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cyc     <= w_cyc_nxt;
            r_we      <= w_we_nxt;
            r_sel     <= w_sel_nxt;
            r_adr     <= w_adr_nxt;
            r_dat     <= w_dat_nxt;
            r_slv_sel <= w_slv_sel_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ready   <= w_ready_nxt;
            r_rdata   <= w_rdata_nxt;
            r_timeout <= w_timeout_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign iomem_ready   = r_ready;
    assign iomem_rdata   = r_rdata;
    assign wbm_cyc_o     = r_cyc;
    assign wbm_stb_o     = r_cyc;
    assign wbm_we_o      = r_we;
    assign wbm_sel_o     = r_sel;
    assign wbm_adr_o     = r_adr;
    assign wbm_dat_o     = r_dat;
    assign wbm_slv_sel_o = r_slv_sel;
    assign timeout_o     = r_timeout;
    assign err_count_o   = r_err;
endmodule

// File: tb/tb_iomem_wb_bridge.sv
// Bench for iomem_wb_bridge: directed and random transfers against an expectation model derived from the bridge's timing rules.
module tb_iomem_wb_bridge;
    localparam int NS      = 3;
    localparam int TIMEOUT = 255;
    localparam int LIMIT   = TIMEOUT + 10;

    logic            clk = 1'b0;
    logic            reset;
    logic            iomem_valid;
    logic            iomem_ready;
    logic [3:0]      iomem_wstrb;
    logic [31:0]     iomem_addr;
    logic [31:0]     iomem_wdata;
    logic [31:0]     iomem_rdata;
    logic            wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]      wbm_sel_o;
    logic [31:0]     wbm_adr_o, wbm_dat_o;
    logic [NS-1:0]   wbm_slv_sel_o;
    logic [NS-1:0]   wbm_ack_i;
    logic [32*NS-1:0] wbm_dat_i;
    logic            timeout_o;
    logic [7:0]      err_count_o;

    int checks = 0;
    int errors = 0;
    int model_err = 0;

    iomem_wb_bridge #(
        .WB_BASE(32'h0300_0000), .WB_MASK(32'hFF00_0000), .NUM_SLAVES(NS),
        .SLV_LSB(16), .TO_W(8), .TIMEOUT(TIMEOUT), .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .reset(reset),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_slv_sel_o(wbm_slv_sel_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
        .timeout_o(timeout_o), .err_count_o(err_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat_err();
        return (model_err > 255) ? 32'd255 : 32'(model_err);
    endfunction

    // One iomem request; the bench plays the addressed slave, acking in cyc cycle number 'delay' (counting from 0).
    task automatic xfer(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                        input int delay, input logic [31:0] sdat, input bit distract,
                        input bit full, input string tag);
        int idx, exp_n, exp_cyc, exp_to, rdy_n, to_cnt, cyc_cnt;
        logic [31:0] exp_rd, rd;
        logic [3:0]  exp_sel;
        logic [NS-1:0] exp_oh;
        bit bad_inv, bad_attr, done;
        idx     = int'(addr[17:16]);
        exp_sel = (strb != 4'h0) ? strb : 4'hF;
        exp_oh  = (idx < NS) ? NS'(1 << idx) : '0;
        exp_to  = 0;
        if (idx >= NS) begin
            exp_n = 0; exp_cyc = 0; exp_rd = 32'hDEAD_BEEF; model_err++;
        end else if (delay <= TIMEOUT - 1) begin
            exp_n = delay + 1; exp_cyc = delay + 1; exp_rd = (strb != 4'h0) ? 32'h0 : sdat;
        end else begin
            exp_n = TIMEOUT; exp_cyc = TIMEOUT; exp_rd = 32'hDEAD_BEEF; exp_to = 1; model_err++;
        end
        @(negedge clk);
        iomem_valid = 1'b1; iomem_addr = addr; iomem_wstrb = strb; iomem_wdata = wd;
        rdy_n = -1; to_cnt = 0; cyc_cnt = 0; bad_inv = 0; bad_attr = 0; done = 0; rd = '0;
        for (int n = 0; n < LIMIT && !done; n++) begin
            @(posedge clk); #1;
            wbm_ack_i = '0;
            wbm_dat_i = {$urandom, $urandom, $urandom};
            if (wbm_cyc_o !== wbm_stb_o) bad_inv = 1;
            if (wbm_cyc_o !== 1'b1 && wbm_slv_sel_o !== '0) bad_inv = 1;
            if (timeout_o === 1'b1) to_cnt++;
            if (wbm_cyc_o === 1'b1) begin
                cyc_cnt++;
                if (wbm_adr_o !== addr || wbm_sel_o !== exp_sel || wbm_we_o !== (strb != 4'h0) ||
                    wbm_dat_o !== wd || wbm_slv_sel_o !== exp_oh) bad_attr = 1;
                if (distract) wbm_ack_i = NS'($urandom) & ~exp_oh;
                if (n == delay && idx < NS) begin
                    wbm_ack_i[idx] = 1'b1;
                    wbm_dat_i[32*idx +: 32] = sdat;
                end
            end
            if (iomem_ready === 1'b1) begin
                rdy_n = n; rd = iomem_rdata; done = 1;
                iomem_valid = 1'b0;
            end
        end
        iomem_valid = 1'b0;
        @(posedge clk); #1;
        wbm_ack_i = '0;
        chk({tag, " ready_cycle"}, 32'(rdy_n), 32'(exp_n));
        chk({tag, " rdata"}, rd, exp_rd);
        chk({tag, " err_count"}, {24'h0, err_count_o}, sat_err());
        if (full) begin
            chk({tag, " cyc_cycles"}, 32'(cyc_cnt), 32'(exp_cyc));
            chk({tag, " timeout_pulses"}, 32'(to_cnt + (timeout_o === 1'b1 ? 1 : 0)), 32'(exp_to));
            chk({tag, " bus_attrs"}, 32'(bad_attr), 32'd0);
            chk({tag, " cyc_stb_sel_invariant"}, 32'(bad_inv), 32'd0);
            chk({tag, " ready_one_cycle"}, {31'h0, iomem_ready}, 32'd0);
        end
    endtask

    initial begin
        int cnt;
        logic [31:0] a;
        reset = 1'b1; iomem_valid = 1'b0; iomem_wstrb = '0; iomem_addr = '0; iomem_wdata = '0;
        wbm_ack_i = '0; wbm_dat_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset cyc", {31'h0, wbm_cyc_o}, 32'd0);
        chk("reset stb", {31'h0, wbm_stb_o}, 32'd0);
        chk("reset ready", {31'h0, iomem_ready}, 32'd0);
        chk("reset rdata", iomem_rdata, 32'd0);
        chk("reset slv_sel", {29'h0, wbm_slv_sel_o}, 32'd0);
        chk("reset err", {24'h0, err_count_o}, 32'd0);
        chk("reset timeout", {31'h0, timeout_o}, 32'd0);
        @(negedge clk); reset = 1'b0;

        xfer(32'h0301_0000, 4'h0, 32'h0, 3, 32'h1234_5678, 0, 1, "rd_slv1");
        xfer(32'h0300_0010, 4'b0100, 32'h00AB_0000, 0, 32'h5555_AAAA, 0, 1, "wr_byte_slv0");
        xfer(32'h0302_0000, 4'h0, 32'h0, 1000, 32'h0, 0, 1, "timeout_slv2");
        xfer(32'h0303_0000, 4'h0, 32'h0, 0, 32'h0, 0, 1, "unmapped_idx3");
        xfer(32'h0301_0004, 4'h0, 32'h0, 5, 32'hCAFE_F00D, 1, 1, "stray_acks");
        xfer(32'h0301_0008, 4'h0, 32'h0, TIMEOUT - 1, 32'h0BAD_C0DE, 1, 1, "ack_at_timeout");

        // Out-of-region request: the bridge must stay silent.
        @(negedge clk);
        iomem_valid = 1'b1; iomem_addr = 32'h0200_0000; iomem_wstrb = 4'h0;
        cnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (wbm_cyc_o !== 1'b0 || iomem_ready !== 1'b0) cnt++;
        end
        iomem_valid = 1'b0;
        chk("region_miss silent", 32'(cnt), 32'd0);

        // Reset while a transfer to a silent slave is in flight.
        @(negedge clk);
        iomem_valid = 1'b1; iomem_addr = 32'h0301_0000; iomem_wstrb = 4'h0;
        repeat (5) @(posedge clk);
        #1;
        chk("midreset cyc_before", {31'h0, wbm_cyc_o}, 32'd1);
        @(negedge clk); reset = 1'b1; iomem_valid = 1'b0;
        @(posedge clk); #1;
        model_err = 0;
        chk("midreset cyc_after", {31'h0, wbm_cyc_o}, 32'd0);
        chk("midreset slv_sel", {29'h0, wbm_slv_sel_o}, 32'd0);
        @(negedge clk); reset = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (iomem_ready !== 1'b0) cnt++;
        end
        chk("midreset no_ready", 32'(cnt), 32'd0);
        chk("midreset err", {24'h0, err_count_o}, 32'd0);

        for (int t = 0; t < 40; t++) begin
            int dly;
            logic [3:0] st;
            a = 32'h0300_0000 | (32'($urandom_range(0, 3)) << 16) | (32'($urandom_range(0, 16383)) << 2);
            st = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            dly = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 1) : $urandom_range(0, 6);
            xfer(a, st, $urandom, dly, $urandom, bit'($urandom_range(0, 1)), 1, "random");
        end

        for (int t = 0; t < 300; t++)
            xfer(32'h0303_0000 | 32'($urandom_range(0, 255)), 4'h0, 32'h0, 0, 32'h0, 0, 0, "saturate");
        chk("saturate final", {24'h0, err_count_o}, 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
